joy_scan_sequencer: RTL and testbench



---
 rtl/joy_pkg.sv | 26 ++
 rtl/joy_tick_gen.sv | 26 ++
 rtl/joy_scan_sequencer.sv | 156 +++++++++++++++
 tb/tb_joy_scan_sequencer.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/joy_pkg.sv
// Shared types and constants for the joystick scan sequencer.
package joy_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SEL,
      S_SETTLE,
      S_LOAD,
      S_SHIFT,
      S_STORE
   } state_t;

   // Chain bit positions where each port's 6-bit field starts
   localparam int J1_BASE = 4;
   localparam int J2_BASE = 12;

   // Field indices inside a 6-bit port sample {p9,p6,R,L,D,U}
   localparam int U       = 0;
   localparam int D       = 1;
   localparam int L       = 2;
   localparam int R       = 3;
   localparam int P6      = 4;
   localparam int P9      = 5;
   localparam int FIELD_W = 6;

endpackage

// File: rtl/joy_tick_gen.sv
// Free-running divider: one-clk tick every CLK_DIV system clocks.
module joy_tick_gen #(
   parameter int CLK_DIV = 4
) (
   input  logic clk,
   input  logic reset,
   output logic tick
);

   localparam int CW = $clog2(CLK_DIV);

   logic [CW-1:0] div_cnt;

   // Wrap the divider at CLK_DIV-1; reset restarts it from 0
   always_ff @(posedge clk) begin
      if (reset)
         div_cnt <= '0;
      else if (div_cnt == CW'(CLK_DIV - 1))
         div_cnt <= '0;
      else
         div_cnt <= div_cnt + 1'b1;
   end

   assign tick = (div_cnt == CW'(CLK_DIV - 1));

endmodule

// File: rtl/joy_scan_sequencer.sv
// Per-frame 8-phase SELECT/load/shift burst over the joystick chain,
// emitting both ports' 6-bit samples tagged with the phase index.
module joy_scan_sequencer
   import joy_pkg::*;
#(
   parameter int CLK_DIV    = 4,
   parameter int SETTLE     = 32,
   parameter int CHAIN_BITS = 18,
   parameter int PHASES     = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       frame_tick,
   input  logic       enable,
   input  logic       joy_data,
   output logic       joy_clk,
   output logic       joy_load_n,
   output logic       joy_sel,
   output logic       phase_valid,
   output logic [2:0] phase_idx,
   output logic [5:0] phase_j1,
   output logic [5:0] phase_j2,
   output logic       busy,
   output logic       overrun
);

   localparam int SW = $clog2(SETTLE + 1);
   localparam int BW = $clog2(CHAIN_BITS + 1);

   state_t        state, state_next;
   logic          tick;
   logic [SW-1:0] settle_cnt;
   logic [BW-1:0] bit_cnt;
   logic          half_b;
   logic [2:0]    phase;
   logic [5:0]    j1_raw, j2_raw;
   logic          in_j1, in_j2, last_bit, last_settle, last_phase;
   logic [2:0]    j1_pos, j2_pos;

   joy_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
      .clk   (clk),
      .reset (reset),
      .tick  (tick)
   );

   // Only chain bits that land in a port field are kept
   assign in_j1       = (bit_cnt >= BW'(J1_BASE)) && (bit_cnt < BW'(J1_BASE + FIELD_W));
   assign in_j2       = (bit_cnt >= BW'(J2_BASE)) && (bit_cnt < BW'(J2_BASE + FIELD_W));
   assign j1_pos      = 3'(bit_cnt - BW'(J1_BASE));
   assign j2_pos      = 3'(bit_cnt - BW'(J2_BASE));
   assign last_bit    = (bit_cnt == BW'(CHAIN_BITS - 1));
   assign last_settle = (settle_cnt == SW'(SETTLE - 1));
   assign last_phase  = (phase == 3'(PHASES - 1));

   // State register
   always_ff @(posedge clk) begin
      if (reset)
         state <= S_IDLE;
      else
         state <= state_next;
   end

   // Next-state: everything except the burst start waits for a tick
   always_comb begin
      state_next = state;
      case (state)
         S_IDLE:   if (frame_tick && enable)          state_next = S_SEL;
         S_SEL:    if (tick)                          state_next = S_SETTLE;
         S_SETTLE: if (tick && last_settle)           state_next = S_LOAD;
         S_LOAD:   if (tick)                          state_next = S_SHIFT;
         S_SHIFT:  if (tick && half_b && last_bit)    state_next = S_STORE;
         S_STORE:  state_next = last_phase ? S_IDLE : S_SEL;
         default:  state_next = S_IDLE;
      endcase
   end

   // Chain control, sampling and registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         joy_clk     <= 1'b0;
         joy_load_n  <= 1'b1;
         joy_sel     <= 1'b1;
         phase_valid <= 1'b0;
         phase_idx   <= '0;
         phase_j1    <= 6'h3F;
         phase_j2    <= 6'h3F;
         busy        <= 1'b0;
         overrun     <= 1'b0;
         phase       <= '0;
         settle_cnt  <= '0;
         bit_cnt     <= '0;
         half_b      <= 1'b0;
      end else begin
         phase_valid <= 1'b0;
         if (frame_tick && state != S_IDLE)
            overrun <= 1'b1;
         case (state)
            S_IDLE: begin
               if (frame_tick && enable) begin
                  busy  <= 1'b1;
                  phase <= '0;
               end
            end
            S_SEL: begin
               if (tick) begin
                  joy_sel    <= ~phase[0];
                  settle_cnt <= '0;
               end
            end
            S_SETTLE: begin
               if (tick) begin
                  settle_cnt <= settle_cnt + 1'b1;
                  if (last_settle)
                     joy_load_n <= 1'b0;
               end
            end
            S_LOAD: begin
               if (tick) begin
                  joy_load_n <= 1'b1;
                  bit_cnt    <= '0;
                  half_b     <= 1'b0;
               end
            end
            S_SHIFT: begin
               if (tick) begin
                  if (!half_b) begin
                     joy_clk <= 1'b0;
                     if (in_j1) j1_raw[j1_pos] <= joy_data;
                     if (in_j2) j2_raw[j2_pos] <= joy_data;
                     half_b  <= 1'b1;
                  end else begin
                     // No rising edge after the last bit: the chain is done
                     joy_clk <= ~last_bit;
                     half_b  <= 1'b0;
                     bit_cnt <= bit_cnt + 1'b1;
                  end
               end
            end
            S_STORE: begin
               phase_valid <= 1'b1;
               phase_idx   <= phase;
               phase_j1    <= {j1_raw[P9], j1_raw[P6], j1_raw[R], j1_raw[L], j1_raw[D], j1_raw[U]};
               phase_j2    <= {j2_raw[P9], j2_raw[P6], j2_raw[R], j2_raw[L], j2_raw[D], j2_raw[U]};
               if (last_phase) begin
                  joy_sel <= 1'b1;
                  busy    <= 1'b0;
               end else begin
                  phase <= phase + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_joy_scan_sequencer.sv
// Scoreboard bench: a physical chain/pad model feeds the DUT, expected
// per-phase samples are queued at burst start and popped on phase_valid.
`timescale 1ns/1ps
module tb_joy_scan_sequencer;

   localparam int PHASES    = 8;
   localparam int PHASE_CLK = 4 * (1 + 32 + 1 + 2 * 18);
   localparam int BURST_CLK = PHASES * PHASE_CLK;

   logic       clk = 1'b0;
   logic       reset, frame_tick, enable, joy_data;
   logic       joy_clk, joy_load_n, joy_sel, phase_valid, busy, overrun;
   logic [2:0] phase_idx;
   logic [5:0] phase_j1, phase_j2;

   typedef struct {
      logic [2:0] idx;
      logic [5:0] j1;
      logic [5:0] j2;
   } exp_t;

   exp_t        exp_q[$];
   exp_t        mon_e;
   int          errors = 0, checks = 0, cyc = 0, strobes = 0, last_cyc = 0;
   bit          model_busy = 1'b0, exp_overrun = 1'b0, three_btn = 1'b0;
   logic [17:0] pad_hi = 18'h3FFFF, pad_lo = 18'h3FFFF;
   logic [17:0] sr = 18'h3FFFF;
   logic        jc_prev = 1'b0;

   joy_scan_sequencer dut (
      .clk         (clk),
      .reset       (reset),
      .frame_tick  (frame_tick),
      .enable      (enable),
      .joy_data    (joy_data),
      .joy_clk     (joy_clk),
      .joy_load_n  (joy_load_n),
      .joy_sel     (joy_sel),
      .phase_valid (phase_valid),
      .phase_idx   (phase_idx),
      .phase_j1    (phase_j1),
      .phase_j2    (phase_j2),
      .busy        (busy),
      .overrun     (overrun)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Pad + chain: parallel load while load_n low, shift on joy_clk rise
   assign joy_data = sr[0];
   always @(posedge clk) begin
      jc_prev <= joy_clk;
      if (!joy_load_n)
         sr <= joy_sel ? pad_hi : pad_lo;
      else if (joy_clk && !jc_prev)
         sr <= {1'b1, sr[17:1]};
   end

   task automatic chk(input string name, input int act, input int expv);
      checks++;
      if (act != expv) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   // Monitor: pop the expected sample on each strobe
   always @(negedge clk) begin
      if (phase_valid) begin
         strobes = strobes + 1;
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_strobe: got idx %0d expected no strobe", phase_idx);
         end else begin
            mon_e = exp_q.pop_front();
            chk("phase_idx", int'(phase_idx), int'(mon_e.idx));
            chk("phase_j1", int'(phase_j1), int'(mon_e.j1));
            chk("phase_j2", int'(phase_j2), int'(mon_e.j2));
            chk("joy_sel_at_strobe", int'(joy_sel),
                (mon_e.idx == 3'(PHASES - 1)) ? 1 : (mon_e.idx[0] ? 0 : 1));
            if (three_btn)
               chk("three_btn_LR", int'(phase_j1[3:2]), mon_e.idx[0] ? 0 : 3);
            if (mon_e.idx != 3'd0)
               chk("strobe_spacing", cyc - last_cyc, PHASE_CLK);
            last_cyc = cyc;
            if (mon_e.idx == 3'(PHASES - 1))
               model_busy = 1'b0;
         end
      end
   end

   // Issue a frame_tick; the model decides start vs overrun from its own view
   task automatic pulse_frame();
      exp_t        e;
      logic [17:0] pad;
      @(negedge clk);
      if (model_busy) begin
         exp_overrun = 1'b1;
      end else if (enable) begin
         model_busy = 1'b1;
         for (int p = 0; p < PHASES; p++) begin
            pad   = (p % 2 == 0) ? pad_hi : pad_lo;
            e.idx = 3'(p);
            e.j1  = pad[9:4];
            e.j2  = pad[17:12];
            exp_q.push_back(e);
         end
      end
      frame_tick = 1'b1;
      @(negedge clk);
      frame_tick = 1'b0;
   endtask

   task automatic wait_idle(input string name, input int budget, output int took);
      int n = 0;
      while ((busy || model_busy) && n < budget) begin
         @(negedge clk);
         n++;
      end
      took = n;
      if (n >= budget) begin
         checks++;
         errors++;
         $display("FAIL %s: got timeout after %0d clk expected idle", name, n);
      end
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, "_joy_clk"}, int'(joy_clk), 0);
      chk({tag, "_joy_load_n"}, int'(joy_load_n), 1);
      chk({tag, "_joy_sel"}, int'(joy_sel), 1);
      chk({tag, "_phase_valid"}, int'(phase_valid), 0);
      chk({tag, "_phase_idx"}, int'(phase_idx), 0);
      chk({tag, "_phase_j1"}, int'(phase_j1), 'h3F);
      chk({tag, "_phase_j2"}, int'(phase_j2), 'h3F);
      chk({tag, "_busy"}, int'(busy), 0);
      chk({tag, "_overrun"}, int'(overrun), 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no finish expected finish by 2ms");
      $fatal(1);
   end

   initial begin
      int took, s0;
      reset = 1'b1; frame_tick = 1'b0; enable = 1'b1;
      repeat (5) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check_reset_vals("rst");

      // Idle for 1000 clk: nothing moves
      repeat (1000) @(negedge clk);
      chk("idle_sel", int'(joy_sel), 1);
      chk("idle_load_n", int'(joy_load_n), 1);
      chk("idle_clk", int'(joy_clk), 0);
      chk("idle_busy", int'(busy), 0);
      chk("idle_strobes", strobes, 0);

      // All-released pad
      pad_hi = 18'h3FFFF; pad_lo = 18'h3FFFF;
      s0 = strobes;
      pulse_frame();
      wait_idle("burst_ones", BURST_CLK + 200, took);
      chk("busy_len_in_range", (took >= BURST_CLK - 15 && took <= BURST_CLK + 20) ? 1 : 0, 1);
      chk("ones_strobe_count", strobes - s0, PHASES);
      chk("sel_after_burst", int'(joy_sel), 1);

      // Port 1 U pressed, port 2 P9 pressed
      pad_hi = 18'h3FFFF & ~(18'd1 << 4) & ~(18'd1 << 17);
      pad_lo = pad_hi;
      pulse_frame();
      wait_idle("burst_u_p9", BURST_CLK + 200, took);

      // 3-button pad: SELECT low forces L and R low on both ports
      pad_hi = 18'($urandom) | 18'h0C0C0;
      pad_lo = pad_hi & ~18'h0C0C0;
      three_btn = 1'b1;
      pulse_frame();
      wait_idle("burst_3btn", BURST_CLK + 200, took);
      three_btn = 1'b0;

      // enable low blocks a new start
      enable = 1'b0;
      pulse_frame();
      repeat (20) @(negedge clk);
      chk("disabled_no_start", int'(busy), 0);
      chk("disabled_no_overrun", int'(overrun), 0);
      enable = 1'b1;

      // Random pad; enable dropped mid-burst, extra frame_tick at 500 clk
      pad_hi = 18'($urandom); pad_lo = 18'($urandom);
      s0 = strobes;
      pulse_frame();
      repeat (300) @(negedge clk);
      enable = 1'b0;
      repeat (198) @(negedge clk);
      pulse_frame();
      chk("overrun_set", int'(overrun), int'(exp_overrun));
      wait_idle("burst_overrun", BURST_CLK + 200, took);
      repeat (600) @(negedge clk);
      chk("overrun_strobe_count", strobes - s0, PHASES);
      chk("no_second_burst", int'(busy), 0);
      chk("overrun_sticky", int'(overrun), 1);
      enable = 1'b1;

      // Reset during SHIFT of phase 3
      pad_hi = 18'($urandom); pad_lo = 18'($urandom);
      s0 = strobes;
      pulse_frame();
      took = 0;
      while (strobes < s0 + 3 && took < 4 * PHASE_CLK) begin
         @(negedge clk);
         took++;
      end
      chk("reached_phase3", strobes - s0, 3);
      repeat (150) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      exp_q.delete();
      model_busy = 1'b0;
      exp_overrun = 1'b0;
      check_reset_vals("midrst");
      reset = 1'b0;
      s0 = strobes;
      repeat (1000) @(negedge clk);
      chk("post_reset_no_strobe", strobes - s0, 0);
      chk("post_reset_busy", int'(busy), 0);

      // Fresh bursts with random pads start again at phase 0
      for (int k = 0; k < 2; k++) begin
         pad_hi = 18'($urandom); pad_lo = 18'($urandom);
         pulse_frame();
         wait_idle("burst_random", BURST_CLK + 200, took);
         repeat ($urandom_range(1, 40)) @(negedge clk);
      end

      chk("queue_empty", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
